// File: rtl/scroll_tile_engine_if.sv
// Host register/memory bus for scroll_tile_engine.
// One-cycle access strobes; read data returns with a one-cycle rvalid pulse.
interface scroll_tile_engine_if;
  logic        host_req;
  logic        host_we;
  logic [1:0]  host_sel;
  logic [15:0] host_addr;
  logic [23:0] host_wdata;
  logic [23:0] host_rdata;
  logic        host_rvalid;

  modport master (output host_req, host_we, host_sel, host_addr, host_wdata,
                  input  host_rdata, host_rvalid);
  modport slave  (input  host_req, host_we, host_sel, host_addr, host_wdata,
                  output host_rdata, host_rvalid);
endinterface

// File: rtl/scroll_tile_engine.sv
// 2-D scrolling tile renderer: tilemap -> tileset -> palette with fixed 3-cycle video latency.
// Optional TILE_FLIP_EN: map entries carry hflip/vflip bits above the tile index.
module scroll_tile_engine #(
  parameter int TILE_LOG2     = 4,
  parameter int MAP_COLS_LOG2 = 6,
  parameter int MAP_ROWS_LOG2 = 5,
  parameter int TILE_IDX_BITS = 6,
  parameter int COLOR_BITS    = 4,
  parameter int VACTIVE       = 480
) (
  input  logic       VGA_CLK,
  input  logic       VGA_RESET_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       blank_n_in,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_n,
  scroll_tile_engine_if.slave host
);
  localparam int EX_W   = MAP_COLS_LOG2 + TILE_LOG2;
  localparam int EY_W   = MAP_ROWS_LOG2 + TILE_LOG2;
  localparam int MAP_AW = MAP_ROWS_LOG2 + MAP_COLS_LOG2;
  localparam int TS_AW  = TILE_IDX_BITS + 2*TILE_LOG2;
  localparam int STAGES = 3;
`ifdef TILE_FLIP_EN
  localparam int MAP_W  = TILE_IDX_BITS + 2;
`else
  localparam int MAP_W  = TILE_IDX_BITS;
`endif

  typedef struct packed { logic hs; logic vs; logic blank_n; } sync_t;
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

  logic [EX_W-1:0] scroll_x_pnd, scroll_x_act, scroll_x_nxt;
  logic [EY_W-1:0] scroll_y_pnd, scroll_y_act, scroll_y_nxt;
  logic [23:0]     bg_color;
  logic [7:0]      frame_cnt;
  logic            frame_latch;
  logic            host_wr, host_rd, reg_wr;
  logic [1:0]      reg_a;

  assign host_wr     = host.host_req & host.host_we;
  assign host_rd     = host.host_req & ~host.host_we;
  assign reg_wr      = host_wr && (host.host_sel == 2'b11);
  assign reg_a       = host.host_addr[1:0];
  assign frame_latch = (hcount == 10'd0) && (vcount == 10'(VACTIVE));

  always_comb begin
    scroll_x_nxt = scroll_x_pnd;
    scroll_y_nxt = scroll_y_pnd;
    if (reg_wr && reg_a == 2'd0) scroll_x_nxt = host.host_wdata[EX_W-1:0];
    if (reg_wr && reg_a == 2'd1) scroll_y_nxt = host.host_wdata[EY_W-1:0];
  end

  // Latching from the *next* pending value lets a write on the latch cycle take effect this frame.
  always_ff @(posedge VGA_CLK or negedge VGA_RESET_n) begin
    if (!VGA_RESET_n) begin
      scroll_x_pnd <= '0;
      scroll_y_pnd <= '0;
      scroll_x_act <= '0;
      scroll_y_act <= '0;
      bg_color     <= '0;
      frame_cnt    <= '0;
    end else begin
      scroll_x_pnd <= scroll_x_nxt;
      scroll_y_pnd <= scroll_y_nxt;
      if (reg_wr && reg_a == 2'd2) bg_color <= host.host_wdata;
      if (frame_latch) begin
        scroll_x_act <= scroll_x_nxt;
        scroll_y_act <= scroll_y_nxt;
        frame_cnt    <= frame_cnt + 8'd1;
      end
    end
  end

  // Host read response
  logic [1:0]  sel_q;
  logic        rvalid_q;
  logic [23:0] reg_q, rdata_mux;

  always_ff @(posedge VGA_CLK or negedge VGA_RESET_n) begin
    if (!VGA_RESET_n) begin
      rvalid_q <= 1'b0;
      sel_q    <= 2'b00;
      reg_q    <= '0;
    end else begin
      rvalid_q <= host_rd;
      if (host_rd) begin
        sel_q <= host.host_sel;
        unique case (reg_a)
          2'd0:    reg_q <= 24'(scroll_x_pnd);
          2'd1:    reg_q <= 24'(scroll_y_pnd);
          2'd2:    reg_q <= bg_color;
          default: reg_q <= 24'(frame_cnt);
        endcase
      end
    end
  end

  // Video coordinates, wrapping by truncation
  logic [EX_W-1:0]   ex;
  logic [EY_W-1:0]   ey;
  logic [MAP_AW-1:0] map_vaddr;
  assign ex        = EX_W'(hcount) + scroll_x_act;
  assign ey        = EY_W'(vcount) + scroll_y_act;
  assign map_vaddr = {ey[EY_W-1:TILE_LOG2], ex[EX_W-1:TILE_LOG2]};

  // S1: tilemap. Port A = host, port B = video; read-before-write on both.
  logic [MAP_W-1:0]     map_mem [2**MAP_AW];
  logic [MAP_W-1:0]     map_q, map_hq;
  logic [TILE_LOG2-1:0] fx1, fy1;
  always_ff @(posedge VGA_CLK) begin
    if (host_wr && host.host_sel == 2'b00)
      map_mem[host.host_addr[MAP_AW-1:0]] <= host.host_wdata[MAP_W-1:0];
    map_hq <= map_mem[host.host_addr[MAP_AW-1:0]];
    map_q  <= map_mem[map_vaddr];
    fx1    <= ex[TILE_LOG2-1:0];
    fy1    <= ey[TILE_LOG2-1:0];
  end

  // S2: tileset
  logic [TILE_LOG2-1:0] fx_eff, fy_eff;
`ifdef TILE_FLIP_EN
  assign fx_eff = map_q[TILE_IDX_BITS]   ? ~fx1 : fx1;
  assign fy_eff = map_q[TILE_IDX_BITS+1] ? ~fy1 : fy1;
`else
  assign fx_eff = fx1;
  assign fy_eff = fy1;
`endif

  logic [TS_AW-1:0]      ts_vaddr;
  logic [COLOR_BITS-1:0] ts_mem [2**TS_AW];
  logic [COLOR_BITS-1:0] ts_q, ts_hq;
  assign ts_vaddr = {map_q[TILE_IDX_BITS-1:0], fy_eff, fx_eff};
  always_ff @(posedge VGA_CLK) begin
    if (host_wr && host.host_sel == 2'b01)
      ts_mem[host.host_addr[TS_AW-1:0]] <= host.host_wdata[COLOR_BITS-1:0];
    ts_hq <= ts_mem[host.host_addr[TS_AW-1:0]];
    ts_q  <= ts_mem[ts_vaddr];
  end

  // S3: palette. Video reads combinationally into the output register; stored as {R,G,B}.
  logic [23:0] pal_mem [2**COLOR_BITS];
  logic [23:0] pal_hq;
  always_ff @(posedge VGA_CLK) begin
    if (host_wr && host.host_sel == 2'b10)
      pal_mem[host.host_addr[COLOR_BITS-1:0]] <= host.host_wdata;
    pal_hq <= pal_mem[host.host_addr[COLOR_BITS-1:0]];
  end

  sync_t [STAGES-1:0] sync_pipe;
  sync_t              sync_in;
  logic  [23:0]       pix_rgb, rgb_q;
  assign sync_in = '{hs: hs_in, vs: vs_in, blank_n: blank_n_in};

  // bg_color is held {B,G,R}; reorder to the {R,G,B} output packing.
  always_comb begin
    pix_rgb = pal_mem[ts_q];
    if (ts_q == '0) pix_rgb = {bg_color[7:0], bg_color[15:8], bg_color[23:16]};
    if (!sync_pipe[STAGES-2].blank_n) pix_rgb = '0;
  end

  always_ff @(posedge VGA_CLK or negedge VGA_RESET_n) begin
    if (!VGA_RESET_n) begin
      sync_pipe <= {STAGES{SYNC_IDLE}};
      rgb_q     <= '0;
    end else begin
      sync_pipe <= {sync_pipe[STAGES-2:0], sync_in};
      rgb_q     <= pix_rgb;
    end
  end

  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign VGA_HS      = sync_pipe[STAGES-1].hs;
  assign VGA_VS      = sync_pipe[STAGES-1].vs;
  assign VGA_BLANK_n = sync_pipe[STAGES-1].blank_n;

  always_comb begin
    rdata_mux = '0;
    unique case (sel_q)
      2'b00:   rdata_mux = 24'(map_hq);
      2'b01:   rdata_mux = 24'(ts_hq);
      2'b10:   rdata_mux = pal_hq;
      default: rdata_mux = reg_q;
    endcase
  end

  assign host.host_rvalid = rvalid_q;
  assign host.host_rdata  = rvalid_q ? rdata_mux : '0;

  logic unused;
  assign unused = &{1'b0, vcount, host.host_addr, host.host_wdata};
endmodule
